// File: rtl/mp3_frame_capture_if.sv
// Byte-stream, release and BRAM read-back signals of the MP3 frame capture.
// The master drives the byte stream and reads back banks; the slave is the capture block.
interface mp3_frame_capture_if #(
  parameter int FRAME_BYTES = 512
);
  localparam int AW = $clog2(FRAME_BYTES);

  logic          axiiv;
  logic [7:0]    axiid;
  logic          flush;
  logic          rel_v;
  logic          rel_bank;
  logic [AW:0]   rd_addr;
  logic [7:0]    rd_data;
  logic          frame_rdy;
  logic          frame_bank;
  logic [AW:0]   frame_len;
  logic          frame_trunc;
  logic [15:0]   drop_cnt;
  logic          capturing;

  modport master (
    output axiiv, axiid, flush, rel_v, rel_bank, rd_addr,
    input  rd_data, frame_rdy, frame_bank, frame_len,
    input  frame_trunc, drop_cnt, capturing
  );

  modport slave (
    input  axiiv, axiid, flush, rel_v, rel_bank, rd_addr,
    output rd_data, frame_rdy, frame_bank, frame_len,
    output frame_trunc, drop_cnt, capturing
  );
endinterface

// File: rtl/mp3_frame_capture.sv
// Locates MP3 frames by sync word and captures them into two BRAM banks
// that the downstream parser reads back and releases.
module mp3_frame_capture #(
  parameter int FRAME_BYTES = 512,
  parameter int MIN_FRAME   = 4
) (
  input logic              clk,
  input logic              rst_n,
  mp3_frame_capture_if.slave bus
);
  localparam int AW = $clog2(FRAME_BYTES);
  localparam int LW = AW + 1;

  typedef enum logic {HUNT, CAPTURE} state_e;

  state_e          state_q, state_d;
  logic            hold_v_q, hold_v_d;
  logic [7:0]      hold_q, hold_d;
  logic [1:0]      full_q, full_d;
  logic            bank_q, bank_d;
  logic [LW-1:0]   ptr_q, ptr_d;
  logic            rdy_q, rdy_d;
  logic            fbank_q, fbank_d;
  logic [LW-1:0]   flen_q, flen_d;
  logic            ftrunc_q, ftrunc_d;
  logic [15:0]     drop_q, drop_d;
  logic [7:0]      rdata_q;
  logic [7:0]      mem_q [2*FRAME_BYTES];

  logic            sync, free_v, free, other_v;
  logic            boundary, buf_full, drop_inc;
  logic            we;
  logic [AW:0]     waddr;
  logic            capt;

  assign sync     = bus.axiiv && hold_v_q && hold_q == 8'hFF
                    && bus.axiid[7:5] == 3'b111;
  assign free_v   = ~&full_q;
  assign free     = full_q[0];
  assign other_v  = !full_q[~bank_q];
  assign boundary = sync && (ptr_q - LW'(1) >= LW'(MIN_FRAME));
  assign buf_full = ptr_q == LW'(FRAME_BYTES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      full_q   <= '0;
      bank_q   <= 1'b0;
      ptr_q    <= '0;
      rdy_q    <= 1'b0;
      fbank_q  <= 1'b0;
      flen_q   <= '0;
      ftrunc_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
      full_q   <= full_d;
      bank_q   <= bank_d;
      ptr_q    <= ptr_d;
      rdy_q    <= rdy_d;
      fbank_q  <= fbank_d;
      flen_q   <= flen_d;
      ftrunc_q <= ftrunc_d;
      drop_q   <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    full_d   = full_q;
    bank_d   = bank_q;
    ptr_d    = ptr_q;
    rdy_d    = 1'b0;
    fbank_d  = fbank_q;
    flen_d   = flen_q;
    ftrunc_d = ftrunc_q;
    drop_inc = 1'b0;
    we       = 1'b0;
    waddr    = {bank_q, ptr_q[AW-1:0]};
    if (bus.axiiv) begin
      hold_v_d = 1'b1;
      hold_d   = bus.axiid;
    end
    if (bus.rel_v) full_d[bus.rel_bank] = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (sync && free_v) begin
          we      = 1'b1;
          waddr   = {free, AW'(1)};
          bank_d  = free;
          ptr_d   = LW'(2);
          state_d = CAPTURE;
        end else if (sync) begin
          drop_inc = 1'b1;
        end
      end
      CAPTURE: begin
        if (bus.flush) begin
          rdy_d          = 1'b1;
          fbank_d        = bank_q;
          flen_d         = ptr_q;
          ftrunc_d       = 1'b0;
          full_d[bank_q] = 1'b1;
          state_d        = HUNT;
          if (bus.axiiv) hold_v_d = 1'b0;
        end else if (boundary) begin
          // the 0xFF at ptr-1 opens the next frame, not this one
          rdy_d          = 1'b1;
          fbank_d        = bank_q;
          flen_d         = ptr_q - LW'(1);
          ftrunc_d       = 1'b0;
          full_d[bank_q] = 1'b1;
          if (other_v) begin
            we     = 1'b1;
            waddr  = {~bank_q, AW'(1)};
            bank_d = ~bank_q;
            ptr_d  = LW'(2);
          end else begin
            drop_inc = 1'b1;
            state_d  = HUNT;
          end
        end else if (bus.axiiv && buf_full) begin
          rdy_d          = 1'b1;
          fbank_d        = bank_q;
          flen_d         = LW'(FRAME_BYTES);
          ftrunc_d       = 1'b1;
          full_d[bank_q] = 1'b1;
          state_d        = HUNT;
        end else if (bus.axiiv) begin
          we    = 1'b1;
          ptr_d = ptr_q + LW'(1);
        end
      end
    endcase
    drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  always_comb begin
    capt = (state_q == CAPTURE);
  end

  // offset 0 of every frame is the 0xFF sync byte, so it is produced on
  // read and the start of a frame needs only one write
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= bus.axiid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (bus.rd_addr[AW-1:0] == '0) rdata_q <= 8'hFF;
    else rdata_q <= mem_q[bus.rd_addr];
  end

  assign bus.rd_data     = rdata_q;
  assign bus.frame_rdy   = rdy_q;
  assign bus.frame_bank  = fbank_q;
  assign bus.frame_len   = flen_q;
  assign bus.frame_trunc = ftrunc_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.capturing   = capt;
endmodule

// File: tb/tb_mp3_frame_capture.sv
// Scoreboard bench for mp3_frame_capture: expected frames are queued as the
// closing beats are driven and matched against frame_rdy pulses.
module tb_mp3_frame_capture;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  typedef struct {
    logic bank;
    int   len;
    logic trunc;
  } exp_t;

  exp_t sb[$];

  mp3_frame_capture_if #(.FRAME_BYTES(512)) bus ();

  mp3_frame_capture #(
    .FRAME_BYTES(512),
    .MIN_FRAME(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic beat(input logic [7:0] b);
    bus.axiiv = 1'b1;
    bus.axiid = b;
    @(negedge clk);
    bus.axiiv = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic rel(input logic b);
    bus.rel_v    = 1'b1;
    bus.rel_bank = b;
    @(negedge clk);
    bus.rel_v = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_chk(input string tag, input logic [9:0] a,
                        input logic [7:0] e);
    bus.rd_addr = a;
    @(negedge clk);
    chk(tag, {24'd0, bus.rd_data}, {24'd0, e});
  endtask

  task automatic expect_frame(input logic b, input int len, input logic t);
    exp_t e;
    e.bank  = b;
    e.len   = len;
    e.trunc = t;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.frame_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("extra_frame", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("frame_bank", {31'd0, bus.frame_bank}, {31'd0, e.bank});
        chk("frame_len", {22'd0, bus.frame_len}, e.len);
        chk("frame_trunc", {31'd0, bus.frame_trunc}, {31'd0, e.trunc});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t1 [10];
    logic [7:0] t2 [5];
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.axiiv    = 1'b0;
    bus.axiid    = '0;
    bus.flush    = 1'b0;
    bus.rel_v    = 1'b0;
    bus.rel_bank = 1'b0;
    bus.rd_addr  = '0;
    idle(3);
    chk("rst_rdy", {31'd0, bus.frame_rdy}, 0);
    chk("rst_len", {22'd0, bus.frame_len}, 0);
    chk("rst_drop", {16'd0, bus.drop_cnt}, 0);
    chk("rst_capt", {31'd0, bus.capturing}, 0);
    chk("rst_rdata", {24'd0, bus.rd_data}, 0);
    rst_n = 1'b1;
    idle(2);

    // back-to-back frames
    t1[0] = 8'hFF;
    t1[1] = 8'hFB;
    for (int i = 2; i < 10; i++) t1[i] = 8'(i - 1);
    for (int i = 0; i < 10; i++) beat(t1[i]);
    chk("t1_capt", {31'd0, bus.capturing}, 1);
    expect_frame(1'b0, 10, 1'b0);
    beat(8'hFF);
    beat(8'hFB);
    beat(8'h11);
    beat(8'h22);
    expect_frame(1'b1, 4, 1'b0);
    do_flush();
    idle(2);
    chk("t1_capt_off", {31'd0, bus.capturing}, 0);
    for (int i = 0; i < 10; i++) rd_chk("t1_data", 10'(i), t1[i]);
    rd_chk("t1_b1_data", 10'h203, 8'h22);
    rel(1'b0);
    rel(1'b1);

    // garbage before sync
    t2[0] = 8'hFF;
    t2[1] = 8'hE2;
    t2[2] = 8'hAA;
    t2[3] = 8'hBB;
    t2[4] = 8'hCC;
    beat(8'h12);
    beat(8'h34);
    beat(8'hFF);
    beat(8'h00);
    for (int i = 0; i < 5; i++) beat(t2[i]);
    expect_frame(1'b0, 5, 1'b0);
    do_flush();
    idle(2);
    for (int i = 0; i < 5; i++) rd_chk("t2_data", 10'(i), t2[i]);
    rel(1'b0);

    // bank exhaustion
    for (int f = 0; f < 3; f++) begin
      beat(8'hFF);
      if (f == 1) expect_frame(1'b0, 6, 1'b0);
      if (f == 2) expect_frame(1'b1, 6, 1'b0);
      beat(8'hE0);
      for (int i = 1; i <= 4; i++) beat(8'((f << 4) + i));
    end
    idle(2);
    chk("t3_drop", {16'd0, bus.drop_cnt}, 1);
    chk("t3_hunt", {31'd0, bus.capturing}, 0);
    rel(1'b0);
    idle(1);
    beat(8'hFF);
    beat(8'hE0);
    for (int i = 1; i <= 4; i++) beat(8'(8'h50 + i));
    expect_frame(1'b0, 6, 1'b0);
    do_flush();
    idle(2);
    rd_chk("t3_data", 10'h005, 8'h54);
    chk("t3_drop2", {16'd0, bus.drop_cnt}, 1);
    rel(1'b0);
    rel(1'b1);

    // truncation
    beat(8'hFF);
    beat(8'hE0);
    for (int i = 0; i < 598; i++) begin
      if (i == 510) expect_frame(1'b0, 512, 1'b1);
      beat(8'(i) & 8'h7F);
      if (i == 100) chk("t4_capt", {31'd0, bus.capturing}, 1);
    end
    idle(2);
    chk("t4_capt_off", {31'd0, bus.capturing}, 0);
    rd_chk("t4_last", 10'h1FF, 8'h7D);
    rel(1'b0);

    // MIN_FRAME guard
    beat(8'hFF);
    beat(8'hE0);
    beat(8'hFF);
    beat(8'hE0);
    beat(8'h01);
    beat(8'h02);
    expect_frame(1'b0, 6, 1'b0);
    do_flush();
    idle(2);
    rd_chk("t5_ff", 10'h002, 8'hFF);
    rd_chk("t5_e0", 10'h003, 8'hE0);

    // async reset mid-capture, bank 0 still full, frame going to bank 1
    beat(8'hFF);
    beat(8'hE0);
    beat(8'h11);
    beat(8'h22);
    chk("t6_capt", {31'd0, bus.capturing}, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_capt", {31'd0, bus.capturing}, 0);
    chk("t6_rst_drop", {16'd0, bus.drop_cnt}, 0);
    chk("t6_rst_len", {22'd0, bus.frame_len}, 0);
    chk("t6_rst_rdata", {24'd0, bus.rd_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    beat(8'hFF);
    beat(8'hE1);
    beat(8'hAA);
    beat(8'hBB);
    beat(8'hCC);
    expect_frame(1'b0, 5, 1'b0);
    do_flush();
    idle(2);
    chk("t6_drop", {16'd0, bus.drop_cnt}, 0);
    rd_chk("t6_data", 10'h002, 8'hAA);
    chk("sb_left", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
